uart_rx_ext: RTL and testbench

Parametrised oversampling UART receiver. It supports configurable data width, optional parity, 1 or 2 stop bits, 3-sample majority voting and an input synchroniser. It reports framing, parity, break and overrun conditions, and delivers words through a valid/ready handshake while keeping the rx_done_tick pulse. It sits between the shared baud-tick generator (s_tick) and the consumer logic or FIFO.

---
 rtl/uart_rx_ext_if.sv | 26 ++
 rtl/uart_rx_ext.sv | 205 ++++++++++++++++++++
 tb/tb_uart_rx_ext.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ext_if.sv
// Consumer-side bundle of the UART receiver: word, status flags and the
// valid/ready handshake. The receiver takes the master view.
interface uart_rx_ext_if #(
   parameter int DBIT = 8
);
   logic            rx_ready;
   logic [DBIT-1:0] data_out;
   logic            rx_valid;
   logic            rx_done_tick;
   logic            parity_err;
   logic            frame_err;
   logic            break_det;
   logic            overrun;

   modport master (
      input  rx_ready,
      output data_out, rx_valid, rx_done_tick,
      output parity_err, frame_err, break_det, overrun
   );

   modport slave (
      output rx_ready,
      input  data_out, rx_valid, rx_done_tick,
      input  parity_err, frame_err, break_det, overrun
   );
endinterface

// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver: two-flop input synchroniser, 3-sample majority
// vote per bit, optional parity, 1/2 stop bits, break detection and a
// valid/ready output register with overrun reporting.
module uart_rx_ext #(
   parameter int DBIT       = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          rx,
   input  logic          s_tick,
   uart_rx_ext_if.master bus
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] C_MAX  = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] C_V1   = CW'(OVERSAMPLE - 2);
   localparam logic [CW-1:0] C_V0   = CW'(OVERSAMPLE - 3);
   localparam logic [CW-1:0] C_HALF = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0]    D_LAST = 4'(DBIT - 1);
   localparam logic [3:0]    S_LAST = 4'(STOP_BITS - 1);
   localparam logic          ODD    = (PARITY_ODD != 0);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_BRK    = 3'd5;

   logic            sync1_q, sync2_q, rx_s;
   logic [2:0]      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [3:0]      bcnt_q, bcnt_d;
   logic [DBIT-1:0] sr_q, sr_d;
   logic [1:0]      v_q, v_d;
   logic            perr_q, perr_d, pbit_q, pbit_d, fe_q, fe_d;
   logic            vbit, bit_done, done, brk;
   logic [DBIT-1:0] data_q;
   logic            valid_q, valid_d, tick_q, perr_o_q, fe_o_q, brk_o_q, ovr_q, ovr_d;

   assign rx_s     = sync2_q;
   // Majority of the two earlier samples and the live sample at the resolve point.
   assign vbit     = (v_q[0] & v_q[1]) | (v_q[0] & rx_s) | (v_q[1] & rx_s);
   assign bit_done = s_tick && (cnt_q == C_MAX);

   // Two-flop synchroniser; idles high so reset never looks like a start edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
      end
   end

   // Frame sequencing: start qualification, bit windows, vote, checks.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bcnt_d  = bcnt_q;
      sr_d    = sr_q;
      v_d     = v_q;
      perr_d  = perr_q;
      pbit_d  = pbit_q;
      fe_d    = fe_q;
      done    = 1'b0;
      brk     = 1'b0;
      if (s_tick && cnt_q == C_V0) v_d[0] = rx_s;
      if (s_tick && cnt_q == C_V1) v_d[1] = rx_s;
      // Bit windows free-run once past START; wrap on the resolve tick.
      if ((state_q == S_DATA || state_q == S_PARITY || state_q == S_STOP) && s_tick)
         cnt_d = bit_done ? '0 : cnt_q + 1'b1;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = S_START;
         end
         S_START: begin
            if (rx_s) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (s_tick) begin
               if (cnt_q == C_HALF) begin
                  // Mid start bit reached: later windows resolve mid-bit.
                  cnt_d   = '0;
                  bcnt_d  = '0;
                  fe_d    = 1'b0;
                  perr_d  = 1'b0;
                  pbit_d  = 1'b0;
                  state_d = S_DATA;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_DATA: begin
            if (bit_done) begin
               sr_d = {vbit, sr_q[DBIT-1:1]};
               if (bcnt_q == D_LAST) begin
                  bcnt_d  = '0;
                  state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end else begin
                  bcnt_d = bcnt_q + 4'd1;
               end
            end
         end
         S_PARITY: begin
            if (bit_done) begin
               perr_d  = vbit ^ (^sr_q) ^ ODD;
               pbit_d  = vbit;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_done) begin
               fe_d = fe_q | ~vbit;
               if (bcnt_q == S_LAST) begin
                  done    = 1'b1;
                  brk     = (sr_q == '0) && !pbit_q && fe_d;
                  cnt_d   = '0;
                  bcnt_d  = '0;
                  state_d = brk ? S_BRK : S_IDLE;
               end else begin
                  bcnt_d = bcnt_q + 4'd1;
               end
            end
         end
         S_BRK: begin
            cnt_d = '0;
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake: completion wins over accept; overrun only if the old word was lost.
   always_comb begin
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (done) begin
         valid_d = 1'b1;
         ovr_d   = valid_q & ~bus.rx_ready;
      end else if (valid_q && bus.rx_ready) begin
         valid_d = 1'b0;
      end
   end

   // Receiver state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bcnt_q  <= '0;
         sr_q    <= '0;
         v_q     <= '0;
         perr_q  <= 1'b0;
         pbit_q  <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bcnt_q  <= bcnt_d;
         sr_q    <= sr_d;
         v_q     <= v_d;
         perr_q  <= perr_d;
         pbit_q  <= pbit_d;
         fe_q    <= fe_d;
      end
   end

   // Output word, flags and handshake registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q   <= '0;
         valid_q  <= 1'b0;
         tick_q   <= 1'b0;
         perr_o_q <= 1'b0;
         fe_o_q   <= 1'b0;
         brk_o_q  <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         tick_q  <= done;
         if (done) begin
            data_q   <= sr_q;
            perr_o_q <= perr_q;
            fe_o_q   <= fe_d;
            brk_o_q  <= brk;
         end
      end
   end

   assign bus.data_out     = data_q;
   assign bus.rx_valid     = valid_q;
   assign bus.rx_done_tick = tick_q;
   assign bus.parity_err   = perr_o_q;
   assign bus.frame_err    = fe_o_q;
   assign bus.break_det    = brk_o_q;
   assign bus.overrun      = ovr_q;
endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: an 8N1 instance and an 8E1 instance share
// the clock and a tick every 4 clk (16 ticks per bit).
module tb_uart_rx_ext;
   logic clk = 1'b0, reset = 1'b1, rx0 = 1'b1, rx1 = 1'b1, s_tick = 1'b0;
   int   tdiv = 0;
   int   tests = 0, fails = 0;
   int   dn0 = 0, hi0 = 0, dn1 = 0;
   logic p0 = 1'b0, p1 = 1'b0;

   always #5 clk = ~clk;

   always @(negedge clk) begin
      tdiv   = (tdiv + 1) % 4;
      s_tick = (tdiv == 0);
   end

   uart_rx_ext_if #(.DBIT(8)) b0 ();
   uart_rx_ext_if #(.DBIT(8)) b1 ();

   uart_rx_ext dut0 (.clk(clk), .reset(reset), .rx(rx0), .s_tick(s_tick), .bus(b0));
   uart_rx_ext #(.PARITY_EN(1)) dut1 (.clk(clk), .reset(reset), .rx(rx1), .s_tick(s_tick), .bus(b1));

   // Count done pulses (rising edges) and high cycles to catch stretched pulses.
   always @(negedge clk) begin
      if (b0.rx_done_tick) hi0++;
      if (b0.rx_done_tick && !p0) dn0++;
      if (b1.rx_done_tick && !p1) dn1++;
      p0 = b0.rx_done_tick;
      p1 = b1.rx_done_tick;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: observed timeout expected finish");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tk(input int n);
      repeat (n) begin
         @(posedge clk);
         while (!s_tick) @(posedge clk);
      end
      #1;
   endtask

   task automatic drv(input bit sel, input logic lvl, input int n);
      if (sel) rx1 = lvl; else rx0 = lvl;
      tk(n);
   endtask

   // gbit selects a data bit whose middle vote sample is inverted (-1: none).
   task automatic send(input bit sel, input logic [7:0] d, input bit pen, input logic pb,
                       input bit stop_ok, input int gbit);
      drv(sel, 1'b0, 16);
      for (int i = 0; i < 8; i++) begin
         if (i == gbit) begin
            drv(sel, d[i], 6);
            drv(sel, ~d[i], 1);
            drv(sel, d[i], 9);
         end else begin
            drv(sel, d[i], 16);
         end
      end
      if (pen) drv(sel, pb, 16);
      if (stop_ok) drv(sel, 1'b1, 16);
      else begin
         drv(sel, 1'b0, 10);
         drv(sel, 1'b1, 6);
      end
      drv(sel, 1'b1, 4);
      @(negedge clk);
   endtask

   task automatic accept(input bit sel);
      @(negedge clk);
      if (sel) b1.rx_ready = 1'b1; else b0.rx_ready = 1'b1;
      @(negedge clk);
      b0.rx_ready = 1'b0;
      b1.rx_ready = 1'b0;
   endtask

   initial begin
      b0.rx_ready = 1'b0;
      b1.rx_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outs", {b0.rx_valid, b0.rx_done_tick, b0.parity_err, b0.frame_err,
                         b0.break_det, b0.overrun, 2'b00, b0.data_out}, 16'h0000);
      reset = 1'b0;
      tk(8);

      // 1: 0xA5 with one bad vote sample in bit 3
      send(0, 8'hA5, 0, 0, 1, 3);
      chk("t1_data", {8'h0, b0.data_out}, 16'h00A5);
      chk("t1_valid", {15'h0, b0.rx_valid}, 16'h1);
      chk("t1_flags", {12'h0, b0.parity_err, b0.frame_err, b0.break_det, b0.overrun}, 16'h0);
      chk("t1_done_cnt", 16'(dn0), 16'd1);
      chk("t1_done_width", 16'(hi0), 16'd1);
      accept(0);
      chk("t1_accept", {15'h0, b0.rx_valid}, 16'h0);

      // 2: short low pulse is rejected
      drv(0, 1'b0, 4);
      drv(0, 1'b1, 32);
      chk("t2_valid", {15'h0, b0.rx_valid}, 16'h0);
      chk("t2_done_cnt", 16'(dn0), 16'd1);

      // 3: even parity, 0x37 has five ones
      send(1, 8'h37, 1, 1'b0, 1, -1);
      chk("t3_data", {8'h0, b1.data_out}, 16'h0037);
      chk("t3_perr_bad", {15'h0, b1.parity_err}, 16'h1);
      chk("t3_fe", {15'h0, b1.frame_err}, 16'h0);
      accept(1);
      send(1, 8'h37, 1, 1'b1, 1, -1);
      chk("t3_perr_ok", {15'h0, b1.parity_err}, 16'h0);
      chk("t3_done_cnt", 16'(dn1), 16'd2);

      // 4: framing error, then break, then clean frame
      send(0, 8'h55, 0, 0, 0, -1);
      chk("t4_data55", {8'h0, b0.data_out}, 16'h0055);
      chk("t4_fe55", {14'h0, b0.frame_err, b0.break_det}, 16'h2);
      accept(0);
      drv(0, 1'b0, 480);
      @(negedge clk);
      chk("t4_brk_cnt", 16'(dn0), 16'd3);
      chk("t4_brk_data", {8'h0, b0.data_out}, 16'h0000);
      chk("t4_brk_flags", {13'h0, b0.rx_valid, b0.frame_err, b0.break_det}, 16'h7);
      drv(0, 1'b1, 32);
      chk("t4_brk_release", 16'(dn0), 16'd3);
      accept(0);
      send(0, 8'h0F, 0, 0, 1, -1);
      chk("t4_data0f", {8'h0, b0.data_out}, 16'h000F);
      chk("t4_flags0f", {14'h0, b0.frame_err, b0.break_det}, 16'h0);
      accept(0);

      // 5: overrun
      send(0, 8'h11, 0, 0, 1, -1);
      send(0, 8'h22, 0, 0, 1, -1);
      chk("t5_data", {8'h0, b0.data_out}, 16'h0022);
      chk("t5_ovr", {14'h0, b0.rx_valid, b0.overrun}, 16'h3);
      accept(0);
      chk("t5_accept", {15'h0, b0.rx_valid}, 16'h0);
      chk("t5_hold", {8'h0, b0.data_out}, 16'h0022);
      send(0, 8'h33, 0, 0, 1, -1);
      chk("t5_data33", {8'h0, b0.data_out}, 16'h0033);
      chk("t5_ovr33", {14'h0, b0.rx_valid, b0.overrun}, 16'h2);
      chk("t5_done_cnt", 16'(dn0), 16'd7);

      // 6: reset during bit 4, word 0x33 still held
      drv(0, 1'b0, 16);
      drv(0, 1'b0, 16);
      drv(0, 1'b0, 16);
      drv(0, 1'b1, 16);
      drv(0, 1'b1, 16);
      drv(0, 1'b1, 8);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("t6_reset_outs", {b0.rx_valid, b0.rx_done_tick, b0.parity_err, b0.frame_err,
                            b0.break_det, b0.overrun, 2'b00, b0.data_out}, 16'h0000);
      reset = 1'b0;
      drv(0, 1'b1, 32);
      chk("t6_no_frame", 16'(dn0), 16'd7);
      send(0, 8'h3C, 0, 0, 1, -1);
      chk("t6_data", {8'h0, b0.data_out}, 16'h003C);
      chk("t6_flags", {11'h0, b0.rx_valid, b0.parity_err, b0.frame_err, b0.break_det,
                       b0.overrun}, 16'h10);
      chk("t6_done_width", 16'(hi0), 16'd8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
